fir_mac_sched: RTL and testbench



---
 rtl/fir_mac_sched_if.sv | 28 ++
 rtl/fir_mac_sched.sv | 123 ++++++++++++
 tb/tb_fir_mac_sched.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sched_if.sv
// Handshake and coefficient-write bundle for the folded FIR controller.
// The slave modport is the filter's view of the bus; the master modport belongs to whoever drives it.
interface fir_mac_sched_if #(
    parameter int DW = 16,
    parameter int CW = 14,
    parameter int OW = 26
);
    logic                 coef_we;
    logic [2:0]           coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 busy;

    modport master (
        output coef_we, coef_addr, coef_wdata, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  coef_we, coef_addr, coef_wdata, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fir_mac_sched.sv
// Folded NTAPS-tap FIR: one multiplier and one accumulator walk the taps, one per cycle.
// Coefficients sit in a shadow bank and are copied to the active bank when a sample is accepted.
module fir_mac_sched #(
    parameter int NTAPS = 6,
    parameter int DW    = 16,
    parameter int CW    = 14,
    parameter int OW    = 26
) (
    input logic            clk,
    input logic            reset,
    fir_mac_sched_if.slave bus
);
    localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_HOLD} state_t;

    state_t               r_state;
    state_t               w_next;
    logic signed [DW-1:0] r_x      [NTAPS];
    logic signed [CW-1:0] r_shadow [NTAPS];
    logic signed [CW-1:0] r_active [NTAPS];
    logic signed [CW-1:0] w_fwd    [NTAPS];
    logic signed [OW-1:0] r_acc;
    logic [TW-1:0]        r_tap;
    logic signed [OW-1:0] r_out_data;
    logic                 r_out_valid;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_release;
    logic signed [DW-1:0] w_x_sel;
    logic signed [CW-1:0] w_c_sel;
    logic signed [OW-1:0] w_prod;
    logic signed [OW-1:0] w_sum;

    // Shadow bank as seen this cycle, with a same-cycle write already applied.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            w_fwd[k] = r_shadow[k];
            if (bus.coef_we && (bus.coef_addr == 3'(k)))
                w_fwd[k] = bus.coef_wdata;
        end
    end

    always_comb begin
        w_x_sel = '0;
        w_c_sel = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (r_tap == TW'(k)) begin
                w_x_sel = r_x[k];
                w_c_sel = r_active[k];
            end
        end
    end

    // Sign-extending both operands to OW before multiplying yields the full-precision
    // product reduced mod 2^OW, i.e. sign-extension or truncation as the widths dictate.
    assign w_prod = OW'(w_x_sel) * OW'(w_c_sel);
    assign w_sum  = r_acc + w_prod;

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_last    = (r_state == S_MAC) && (r_tap == TW'(NTAPS - 1));
    assign w_release = (r_state == S_HOLD) && bus.out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_MAC;
            S_MAC:   if (w_last)    w_next = S_HOLD;
            S_HOLD:  if (w_release) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_x[k]      <= '0;
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_acc       <= '0;
            r_tap       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            for (int k = 0; k < NTAPS; k++)
                r_shadow[k] <= w_fwd[k];

            if (w_accept) begin
                r_x[0] <= bus.in_data;
                for (int k = 1; k < NTAPS; k++)
                    r_x[k] <= r_x[k-1];
                for (int k = 0; k < NTAPS; k++)
                    r_active[k] <= w_fwd[k];
                r_acc <= '0;
                r_tap <= '0;
            end

            if (r_state == S_MAC) begin
                r_acc <= w_sum;
                r_tap <= r_tap + 1'b1;
                if (w_last) begin
                    r_out_data  <= w_sum;
                    r_out_valid <= 1'b1;
                end
            end

            if (w_release)
                r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: vector table for steady-state results, hand sequences for
// backpressure, coefficient timing, write forwarding and reset during MAC.
module tb_fir_mac_sched;
    localparam int NTAPS = 6;
    localparam int DW    = 16;
    localparam int CW    = 14;
    localparam int OW    = 26;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fir_mac_sched_if #(.DW(DW), .CW(CW), .OW(OW)) bus ();

    fir_mac_sched #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t_acc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic                 wr;
        logic [2:0]           addr;
        logic signed [CW-1:0] cd;
        logic signed [DW-1:0] s;
        logic signed [OW-1:0] exp;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // All tasks start and end at a falling edge; inputs change only there.
    task automatic wr_coef(input logic [2:0] a, input logic signed [CW-1:0] d);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = a;
        bus.coef_wdata = d;
        @(negedge clk);
        bus.coef_we    = 1'b0;
    endtask

    task automatic accept(input logic signed [DW-1:0] s);
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = s;
        @(negedge clk);
        t_acc        = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic signed [OW-1:0] r, output int lat);
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - t_acc;
        r   = bus.out_data;
    endtask

    task automatic run(input logic signed [DW-1:0] s, output logic signed [OW-1:0] r,
                       output int lat);
        accept(s);
        wait_result(r, lat);
        @(negedge clk);
    endtask

    initial begin
        logic signed [OW-1:0] r;
        int lat;
        int seen;

        tv[0]  = '{1'b0, 3'd0, 14'sd0,     16'sd1,      26'sd1};
        tv[1]  = '{1'b0, 3'd0, 14'sd0,     16'sd0,      26'sd2};
        tv[2]  = '{1'b0, 3'd0, 14'sd0,     16'sd0,      26'sd3};
        tv[3]  = '{1'b0, 3'd0, 14'sd0,     16'sd0,      26'sd4};
        tv[4]  = '{1'b0, 3'd0, 14'sd0,     16'sd0,      26'sd5};
        tv[5]  = '{1'b0, 3'd0, 14'sd0,     16'sd0,      26'sd6};
        tv[6]  = '{1'b0, 3'd0, 14'sd0,     16'sd0,      26'sd0};
        tv[7]  = '{1'b1, 3'd0, -14'sd3,    16'sd5,      -26'sd15};
        tv[8]  = '{1'b1, 3'd0, -14'sd8192, -16'sd32768, 26'sd0};
        tv[9]  = '{1'b1, 3'd6, 14'sd77,    16'sd1,      -26'sd8192};
        tv[10] = '{1'b1, 3'd7, 14'sd55,    16'sd2,      -26'sd16384};

        reset          = 1'b1;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready",  longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_busy",      longint'(bus.busy), 0);
        chk("rst_out_data",  longint'(bus.out_data), 0);

        // Impulse response, then arithmetic/ignored-address vectors on c0 only.
        for (int k = 0; k < NTAPS; k++) wr_coef(3'(k), CW'(k + 1));
        for (int i = 0; i < 7; i++) begin
            run(tv[i].s, r, lat);
            chk($sformatf("vec%0d_data", i), longint'(r), longint'(tv[i].exp));
            chk($sformatf("vec%0d_lat", i), lat, NTAPS);
        end
        for (int k = 1; k < NTAPS; k++) wr_coef(3'(k), '0);
        for (int i = 7; i < 11; i++) begin
            if (tv[i].wr) wr_coef(tv[i].addr, tv[i].cd);
            run(tv[i].s, r, lat);
            chk($sformatf("vec%0d_data", i), longint'(r), longint'(tv[i].exp));
            chk($sformatf("vec%0d_lat", i), lat, NTAPS);
        end

        // Backpressure: result held five cycles, in_valid pulses in HOLD must not be taken.
        wr_coef(3'd0, 14'sd1);
        bus.out_ready = 1'b0;
        accept(16'sd3);
        wait_result(r, lat);
        chk("bp_lat",  lat, NTAPS);
        chk("bp_data", longint'(r), 3);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 16'sd99;
            @(negedge clk);
            chk($sformatf("bp_hold%0d_data", i),     longint'(bus.out_data), 3);
            chk($sformatf("bp_hold%0d_valid", i),    longint'(bus.out_valid), 1);
            chk($sformatf("bp_hold%0d_in_ready", i), longint'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_in_ready",  longint'(bus.in_ready), 1);
        chk("bp_rel_out_valid", longint'(bus.out_valid), 0);
        chk("bp_rel_data_kept", longint'(bus.out_data), 3);
        wr_coef(3'd1, 14'sd1);
        run(16'sd0, r, lat);
        chk("bp_no_extra_sample", longint'(r), 3);
        wr_coef(3'd1, 14'sd0);

        // Coefficient written mid-MAC applies only to the following sample.
        accept(16'sd7);
        @(negedge clk);
        chk("mac_busy", longint'(bus.busy), 1);
        wr_coef(3'd0, 14'sd100);
        wait_result(r, lat);
        chk("ct_data_old_coef", longint'(r), 7);
        chk("ct_lat", lat, NTAPS);
        @(negedge clk);
        run(16'sd2, r, lat);
        chk("ct_data_new_coef", longint'(r), 200);

        // Write forwarding on the accepting edge, from a freshly reset state.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_out_data",  longint'(bus.out_data), 0);
        chk("rst2_out_valid", longint'(bus.out_valid), 0);
        bus.in_valid   = 1'b1;
        bus.in_data    = 16'sd1;
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 3'd0;
        bus.coef_wdata = 14'sd9;
        @(negedge clk);
        t_acc          = cyc;
        bus.in_valid   = 1'b0;
        bus.coef_we    = 1'b0;
        wait_result(r, lat);
        chk("fwd_data", longint'(r), 9);
        chk("fwd_lat", lat, NTAPS);
        @(negedge clk);

        // Reset at T+3 discards the result and clears delay line and coefficients.
        wr_coef(3'd0, 14'sd5);
        wr_coef(3'd1, 14'sd5);
        accept(16'sd3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rmac_out_valid", longint'(bus.out_valid), 0);
        chk("rmac_busy",      longint'(bus.busy), 0);
        chk("rmac_in_ready",  longint'(bus.in_ready), 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rmac_no_stale_result", seen, 0);
        run(16'sd4, r, lat);
        chk("rmac_coefs_cleared", longint'(r), 0);
        wr_coef(3'd0, 14'sd1);
        wr_coef(3'd1, 14'sd1);
        run(16'sd6, r, lat);
        chk("rmac_after_data", longint'(r), 10);
        chk("rmac_after_lat", lat, NTAPS);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end
endmodule
